// File: rtl/counter_pkg.sv
// Shared definitions for the bounded up/down counter family.
package counter_pkg;

  localparam logic MODE_SATURATE = 1'b0;
  localparam logic MODE_WRAP     = 1'b1;

  function automatic int clamp(input int value, input int lo, input int hi);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-count and wrap-flag computation for one count step.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 9,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             inc,
  input  logic             dec,
  input  logic             en,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_up,
  output logic             wrap_down
);

  // Two spare bits keep q+STEP and q-STEP exact, including negatives.
  localparam logic signed [WIDTH+1:0] MIN_S  = (WIDTH+2)'(MIN);
  localparam logic signed [WIDTH+1:0] MAX_S  = (WIDTH+2)'(MAX);
  localparam logic signed [WIDTH+1:0] STEP_S = (WIDTH+2)'(STEP);
  localparam logic signed [WIDTH+1:0] ONE_S  = (WIDTH+2)'(1);

  logic signed [WIDTH+1:0] q_s;
  logic signed [WIDTH+1:0] up_s;
  logic signed [WIDTH+1:0] dn_s;
  logic signed [WIDTH+1:0] nxt_s;

  always_comb begin
    q_s       = $signed({2'b00, q});
    up_s      = q_s + STEP_S;
    dn_s      = q_s - STEP_S;
    nxt_s     = q_s;
    wrap_up   = 1'b0;
    wrap_down = 1'b0;
    if (en && inc && !dec) begin
      if (up_s > MAX_S) begin
        if (wrap_mode == MODE_WRAP) begin
          nxt_s   = MIN_S + (up_s - MAX_S - ONE_S);
          wrap_up = 1'b1;
        end else begin
          nxt_s = MAX_S;
        end
      end else begin
        nxt_s = up_s;
      end
    end else if (en && dec && !inc) begin
      if (dn_s < MIN_S) begin
        if (wrap_mode == MODE_WRAP) begin
          nxt_s     = MAX_S + ONE_S - (MIN_S - dn_s);
          wrap_down = 1'b1;
        end else begin
          nxt_s = MIN_S;
        end
      end else begin
        nxt_s = dn_s;
      end
    end
    q_next = nxt_s[WIDTH-1:0];
  end

endmodule

// File: rtl/bounded_up_down_counter.sv
// Up/down counter bounded to [MIN, MAX] with clamped load and cascadable carry/borrow.
module bounded_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 9,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             wrap_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  if (MIN < 0 || MIN >= MAX) begin : g_bad_bounds
    $fatal(1, "bounded_up_down_counter: need 0 <= MIN < MAX");
  end
  if (MAX > (2 ** WIDTH) - 1) begin : g_bad_width
    $fatal(1, "bounded_up_down_counter: MAX does not fit in WIDTH bits");
  end
  if (STEP < 1 || STEP > MAX - MIN) begin : g_bad_step
    $fatal(1, "bounded_up_down_counter: need 1 <= STEP <= MAX-MIN");
  end

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_up;
  logic             wrap_down;

  counter_next_value #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX),
    .STEP  (STEP)
  ) u_next (
    .q         (q),
    .inc       (inc),
    .dec       (dec),
    .en        (en),
    .wrap_mode (wrap_mode),
    .q_next    (q_next),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down)
  );

  assign load_clamped = WIDTH'(clamp(int'(load_val), MIN, MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= MIN_Q;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else if (load) begin
      q      <= load_clamped;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      q      <= q_next;
      carry  <= wrap_up;
      borrow <= wrap_down;
    end
  end

  assign at_max = (q == MAX_Q);
  assign at_min = (q == MIN_Q);

endmodule

// File: tb/tb_bounded_up_down_counter.sv
// Directed bench: default, STEP=3, MIN=2..MAX=12 and a two-digit cascade.
module tb_bounded_up_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Instance A: defaults
  logic a_reset, a_en, a_inc, a_dec, a_wrap, a_load;
  logic [3:0] a_lv, a_q;
  logic a_amax, a_amin, a_carry, a_borrow;
  bounded_up_down_counter dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .inc(a_inc), .dec(a_dec), .wrap_mode(a_wrap),
    .load(a_load), .load_val(a_lv), .q(a_q), .at_max(a_amax), .at_min(a_amin),
    .carry(a_carry), .borrow(a_borrow)
  );

  // Instance B: STEP=3
  logic b_reset, b_inc, b_dec, b_wrap, b_load;
  logic [3:0] b_lv, b_q;
  logic b_amax, b_amin, b_carry, b_borrow;
  bounded_up_down_counter #(.WIDTH(4), .MIN(0), .MAX(9), .STEP(3)) dut_b (
    .clk(clk), .reset(b_reset), .en(1'b1), .inc(b_inc), .dec(b_dec), .wrap_mode(b_wrap),
    .load(b_load), .load_val(b_lv), .q(b_q), .at_max(b_amax), .at_min(b_amin),
    .carry(b_carry), .borrow(b_borrow)
  );

  // Instance C: MIN=2, MAX=12
  logic c_reset, c_inc, c_dec, c_wrap, c_load;
  logic [3:0] c_lv, c_q;
  logic c_amax, c_amin, c_carry, c_borrow;
  bounded_up_down_counter #(.WIDTH(4), .MIN(2), .MAX(12), .STEP(1)) dut_c (
    .clk(clk), .reset(c_reset), .en(1'b1), .inc(c_inc), .dec(c_dec), .wrap_mode(c_wrap),
    .load(c_load), .load_val(c_lv), .q(c_q), .at_max(c_amax), .at_min(c_amin),
    .carry(c_carry), .borrow(c_borrow)
  );

  // Cascade D0 -> D1
  logic d_reset, d0_inc;
  logic [3:0] d0_q, d1_q;
  logic d0_amax, d0_amin, d0_carry, d0_borrow;
  logic d1_amax, d1_amin, d1_carry, d1_borrow;
  bounded_up_down_counter dut_d0 (
    .clk(clk), .reset(d_reset), .en(1'b1), .inc(d0_inc), .dec(1'b0), .wrap_mode(1'b1),
    .load(1'b0), .load_val(4'd0), .q(d0_q), .at_max(d0_amax), .at_min(d0_amin),
    .carry(d0_carry), .borrow(d0_borrow)
  );
  bounded_up_down_counter dut_d1 (
    .clk(clk), .reset(d_reset), .en(1'b1), .inc(d0_carry), .dec(1'b0), .wrap_mode(1'b1),
    .load(1'b0), .load_val(4'd0), .q(d1_q), .at_max(d1_amax), .at_min(d1_amin),
    .carry(d1_carry), .borrow(d1_borrow)
  );

  typedef struct {
    logic       reset, en, inc, dec, wrap, load;
    logic [3:0] lv;
    int         q;
    logic       amax, amin, c, b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, en, inc, dec, wrap, ld, input logic [3:0] lv,
                              input int q, input logic amax, amin, c, b);
    vec_t v;
    v.reset = rst; v.en = en; v.inc = inc; v.dec = dec; v.wrap = wrap; v.load = ld;
    v.lv = lv; v.q = q; v.amax = amax; v.amin = amin; v.c = c; v.b = b;
    vecs.push_back(v);
  endfunction

  task automatic step_b(input logic rst, ld, input logic [3:0] lv, input logic i, d, w);
    @(negedge clk);
    b_reset = rst; b_load = ld; b_lv = lv; b_inc = i; b_dec = d; b_wrap = w;
    @(posedge clk);
    #1;
  endtask

  task automatic step_c(input logic rst, ld, input logic [3:0] lv, input logic i, d, w);
    @(negedge clk);
    c_reset = rst; c_load = ld; c_lv = lv; c_inc = i; c_dec = d; c_wrap = w;
    @(posedge clk);
    #1;
  endtask

  int exp_q;
  int c0_cnt, c1_cnt;

  initial begin
    a_reset = 1; a_en = 0; a_inc = 0; a_dec = 0; a_wrap = 0; a_load = 0; a_lv = 0;
    b_reset = 1; b_inc = 0; b_dec = 0; b_wrap = 0; b_load = 0; b_lv = 0;
    c_reset = 1; c_inc = 0; c_dec = 0; c_wrap = 0; c_load = 0; c_lv = 0;
    d_reset = 1; d0_inc = 0;

    // ---- Instance A vector table ----
    add(1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      exp_q = (i + 1 > 9) ? 9 : i + 1;
      add(0, 1, 1, 0, 0, 0, 4'd0, exp_q, exp_q == 9, 0, 0, 0);
    end
    for (int i = 0; i < 12; i++) begin
      exp_q = (8 - i < 0) ? 0 : 8 - i;
      add(0, 1, 0, 1, 0, 0, 4'd0, exp_q, 0, exp_q == 0, 0, 0);
    end
    add(0, 0, 0, 0, 1, 1, 4'd9, 9, 1, 0, 0, 0);   // load 9
    add(0, 1, 1, 0, 1, 0, 4'd0, 0, 0, 1, 1, 0);   // wrap up, carry
    add(0, 1, 0, 0, 1, 0, 4'd0, 0, 0, 1, 0, 0);   // carry drops
    add(0, 1, 0, 1, 1, 0, 4'd0, 9, 1, 0, 0, 1);   // wrap down, borrow
    add(0, 0, 1, 0, 1, 0, 4'd0, 9, 1, 0, 0, 0);   // en=0 holds
    add(0, 1, 1, 1, 1, 0, 4'd0, 9, 1, 0, 0, 0);   // inc&dec holds
    add(0, 1, 1, 0, 1, 1, 4'd5, 5, 0, 0, 0, 0);   // load beats inc
    add(0, 0, 0, 0, 0, 1, 4'd15, 9, 1, 0, 0, 0);  // load clamps high
    add(0, 1, 1, 0, 1, 1, 4'd9, 9, 1, 0, 0, 0);   // load at max w/ inc, no carry
    add(1, 1, 1, 0, 1, 1, 4'd7, 0, 0, 1, 0, 0);   // reset beats load/inc
    add(0, 1, 1, 0, 1, 0, 4'd0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 4'd0, 2, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    b_reset = 0; c_reset = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_reset = vecs[i].reset; a_en = vecs[i].en; a_inc = vecs[i].inc; a_dec = vecs[i].dec;
      a_wrap = vecs[i].wrap; a_load = vecs[i].load; a_lv = vecs[i].lv;
      @(posedge clk);
      #1;
      check($sformatf("a[%0d].q", i), int'(a_q), vecs[i].q);
      check($sformatf("a[%0d].at_max", i), int'(a_amax), int'(vecs[i].amax));
      check($sformatf("a[%0d].at_min", i), int'(a_amin), int'(vecs[i].amin));
      check($sformatf("a[%0d].carry", i), int'(a_carry), int'(vecs[i].c));
      check($sformatf("a[%0d].borrow", i), int'(a_borrow), int'(vecs[i].b));
    end

    // ---- STEP=3 ----
    step_b(1, 0, 4'd0, 0, 0, 1);
    check("b.reset.q", int'(b_q), 0);
    step_b(0, 1, 4'd8, 0, 0, 1);
    check("b.load8", int'(b_q), 8);
    step_b(0, 0, 4'd0, 1, 0, 1);
    check("b.wrapup.q", int'(b_q), 1);
    check("b.wrapup.carry", int'(b_carry), 1);
    step_b(0, 1, 4'd1, 0, 0, 1);
    check("b.load1", int'(b_q), 1);
    check("b.carry_gone", int'(b_carry), 0);
    step_b(0, 0, 4'd0, 0, 1, 1);
    check("b.wrapdn.q", int'(b_q), 8);
    check("b.wrapdn.borrow", int'(b_borrow), 1);
    step_b(0, 0, 4'd0, 1, 0, 0);
    check("b.sat.q", int'(b_q), 9);
    check("b.sat.borrow", int'(b_borrow), 0);
    check("b.sat.carry", int'(b_carry), 0);

    // ---- MIN=2, MAX=12 ----
    step_c(1, 0, 4'd0, 0, 0, 0);
    check("c.reset.q", int'(c_q), 2);
    check("c.reset.at_min", int'(c_amin), 1);
    step_c(0, 1, 4'd15, 0, 0, 0);
    check("c.load15", int'(c_q), 12);
    check("c.at_max", int'(c_amax), 1);
    step_c(0, 1, 4'd0, 0, 0, 0);
    check("c.load0", int'(c_q), 2);
    step_c(0, 1, 4'd12, 0, 0, 1);
    step_c(0, 1, 4'd7, 1, 0, 1);
    check("c.loadwins.q", int'(c_q), 7);
    check("c.loadwins.carry", int'(c_carry), 0);
    step_c(0, 1, 4'd12, 0, 0, 1);
    step_c(0, 0, 4'd0, 1, 0, 1);
    check("c.wrap.q", int'(c_q), 2);
    check("c.wrap.carry", int'(c_carry), 1);
    step_c(0, 0, 4'd0, 0, 1, 1);
    check("c.wrapdn.q", int'(c_q), 12);
    check("c.wrapdn.borrow", int'(c_borrow), 1);
    check("c.wrapdn.carry", int'(c_carry), 0);

    // ---- Cascade ----
    @(negedge clk);
    d_reset = 1;
    @(posedge clk);
    #1;
    check("d.reset.d0", int'(d0_q), 0);
    check("d.reset.d1", int'(d1_q), 0);
    @(negedge clk);
    d_reset = 0;
    d0_inc = 1;
    c0_cnt = 0;
    c1_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      c0_cnt += int'(d0_carry);
      c1_cnt += int'(d1_carry);
      if (i == 54) begin
        check("d.mid.d0", int'(d0_q), 5);
        check("d.mid.d1", int'(d1_q), 5);
      end
    end
    check("d.100.d0", int'(d0_q), 0);
    check("d.100.d1", int'(d1_q), 9);
    check("d.100.carry0", int'(d0_carry), 1);
    @(negedge clk);
    d0_inc = 0;
    @(posedge clk);
    #1;
    c1_cnt += int'(d1_carry);
    check("d.end.d0", int'(d0_q), 0);
    check("d.end.d1", int'(d1_q), 0);
    check("d.end.carry1", int'(d1_carry), 1);
    check("d.carry0_count", c0_cnt, 10);
    check("d.carry1_count", c1_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
